// File: rtl/key_delay_module.sv
// rtl/key_delay_module.sv - debounces key edge pulses into clean press/release pulses and a held flag
module key_delay_module #(
    parameter logic [15:0] T1MS        = 16'd49_999,
    parameter logic [3:0]  DEBOUNCE_MS = 4'd10
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic H2L_Sig,
    input  logic L2H_Sig,
    output logic Key_Press,
    output logic Key_Release,
    output logic Key_State
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt_clk, cnt_clk_nxt;
    logic [3:0]  cnt_ms, cnt_ms_nxt;
    logic [3:0]  cnt_ms_inc;
    logic        pend, pend_nxt;
    logic        press_nxt, release_nxt, key_state_nxt;
    logic        edge_any, edge_both, tick, timeout;

    assign edge_any   = H2L_Sig | L2H_Sig;
    assign edge_both  = H2L_Sig & L2H_Sig;
    assign tick       = (cnt_clk == T1MS);
    assign cnt_ms_inc = cnt_ms + 4'd1;
    // Detect the wrap that would make cnt_ms reach DEBOUNCE_MS, so the registered
    // pulse lands exactly DEBOUNCE_MS*(T1MS+1) cycles after the last edge.
    assign timeout    = tick && (cnt_ms_inc == DEBOUNCE_MS);

    always_comb begin
        state_nxt     = state;
        cnt_clk_nxt   = 16'd0;
        cnt_ms_nxt    = 4'd0;
        pend_nxt      = pend;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        key_state_nxt = Key_State;

        case (state)
            IDLE: begin
                key_state_nxt = 1'b0;
                if (H2L_Sig && !L2H_Sig) begin
                    state_nxt = PRESS_WAIT;
                    pend_nxt  = 1'b0;
                end
            end

            HELD: begin
                key_state_nxt = 1'b1;
                if (L2H_Sig && !H2L_Sig) begin
                    state_nxt = RELEASE_WAIT;
                    pend_nxt  = 1'b1;
                end
            end

            PRESS_WAIT, RELEASE_WAIT: begin
                if (edge_any) begin
                    // Edge wins over a coinciding timeout; counters restart via defaults.
                    if (!edge_both)
                        pend_nxt = L2H_Sig;
                end else if (timeout) begin
                    if (state == PRESS_WAIT) begin
                        if (!pend) begin
                            state_nxt     = HELD;
                            press_nxt     = 1'b1;
                            key_state_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        if (pend) begin
                            state_nxt     = IDLE;
                            release_nxt   = 1'b1;
                            key_state_nxt = 1'b0;
                        end else begin
                            state_nxt = HELD;
                        end
                    end
                end else begin
                    cnt_clk_nxt = tick ? 16'd0 : cnt_clk + 16'd1;
                    cnt_ms_nxt  = tick ? cnt_ms_inc : cnt_ms;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= IDLE;
            cnt_clk     <= 16'd0;
            cnt_ms      <= 4'd0;
            pend        <= 1'b1;
            Key_Press   <= 1'b0;
            Key_Release <= 1'b0;
            Key_State   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt_clk     <= cnt_clk_nxt;
            cnt_ms      <= cnt_ms_nxt;
            pend        <= pend_nxt;
            Key_Press   <= press_nxt;
            Key_Release <= release_nxt;
            Key_State   <= key_state_nxt;
        end
    end

    a_no_both_pulses: assert property (@(posedge CLK) disable iff (!RST_n)
        !(Key_Press && Key_Release));
    a_no_back_to_back: assert property (@(posedge CLK) disable iff (!RST_n)
        (Key_Press || Key_Release) |=> !(Key_Press || Key_Release));
    a_cnt_bounds: assert property (@(posedge CLK) disable iff (!RST_n)
        (cnt_clk <= T1MS) && (cnt_ms < DEBOUNCE_MS));

endmodule
